// File: rtl/fir_tap_sequencer_if.sv
// Handshake and datapath-control bundle between the FIR tap sequencer and
// the UART glue, coefficient ROM, delay-line RAM and MAC unit.
interface fir_tap_sequencer_if #(
  parameter int coeff_size = 64
);
  localparam int address_size = $clog2(coeff_size);

  logic                    in_valid;
  logic                    in_ready;
  logic                    buf_wr_en;
  logic [address_size-1:0] buf_wr_addr;
  logic [address_size-1:0] coeff_addr;
  logic [address_size-1:0] sample_addr;
  logic                    mac_clear;
  logic                    mac_en;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, buf_wr_en, buf_wr_addr, coeff_addr, sample_addr,
           mac_clear, mac_en, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, buf_wr_en, buf_wr_addr, coeff_addr, sample_addr,
           mac_clear, mac_en, out_valid, busy
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Control FSM for the FIR datapath: accepts a sample, writes it into the
// circular delay line, walks every tap through the MAC, then offers the result.
module fir_tap_sequencer #(
  parameter int coeff_size  = 64,
  parameter int mac_latency = 2
) (
  input logic                  clock,
  input logic                  reset,
  fir_tap_sequencer_if.master  bus
);
  localparam int address_size = $clog2(coeff_size);

  // The drain phase reuses the tap counter, so mac_latency must fit in k.
  localparam logic [address_size-1:0] tap_last   = address_size'(coeff_size - 1);
  localparam logic [address_size-1:0] drain_last = address_size'(mac_latency - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    OUT
  } state_t;

  state_t                  st;
  logic [address_size-1:0] k;
  logic [address_size-1:0] wp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      k  <= '0;
      wp <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) st <= LOAD;
        end
        LOAD: begin
          k  <= '0;
          st <= MAC;
        end
        MAC: begin
          if (k == tap_last) begin
            k  <= '0;
            wp <= wp + 1'b1;
            st <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (k == drain_last) begin
            k  <= '0;
            st <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) st <= IDLE;
        end
        default: begin
          st <= IDLE;
          k  <= '0;
        end
      endcase
    end
  end

  // Pure decodes of st/k/wp: nothing from the inputs reaches an output.
  assign bus.in_ready    = (st == IDLE);
  assign bus.busy        = (st != IDLE);
  assign bus.buf_wr_en   = (st == LOAD);
  assign bus.mac_clear   = (st == LOAD);
  assign bus.buf_wr_addr = wp;
  assign bus.mac_en      = (st == MAC);
  assign bus.coeff_addr  = (st == MAC) ? k : '0;
  assign bus.sample_addr = (st == MAC) ? (wp - k) : '0;
  assign bus.out_valid   = (st == OUT);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: a transaction-level model predicts
// every output each cycle, with directed scenarios pinning key literal values.
module tb_fir_tap_sequencer;
  localparam int coeffSize  = 64;
  localparam int macLatency = 2;
  localparam int outStart   = coeffSize + macLatency + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fir_tap_sequencer_if #(.coeff_size(coeffSize)) bus ();

  fir_tap_sequencer #(
    .coeff_size (coeffSize),
    .mac_latency(macLatency)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: mBusy marks a transaction in flight, mT counts edges since its accept.
  bit mBusy       = 1'b0;
  int mT          = 0;
  int mWp         = 0;
  int acceptCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mBusy = 1'b0;
      mT    = 0;
      mWp   = 0;
    end else if (!mBusy) begin
      if (bus.in_valid) begin
        mBusy = 1'b1;
        mT    = 0;
        acceptCount++;
      end
    end else if (mT >= outStart) begin
      if (bus.out_ready) mBusy = 1'b0;
    end else begin
      mT++;
      if (mT == coeffSize + 1) mWp = (mWp + 1) % coeffSize;
    end
  end

  always @(negedge clock) begin
    int  tap;
    bit  inMac;
    tap   = mT - 1;
    inMac = mBusy && (mT >= 1) && (mT <= coeffSize);
    checkOutput("inReady",    bus.in_ready,    32'(!mBusy));
    checkOutput("busy",       bus.busy,        32'(mBusy));
    checkOutput("bufWrEn",    bus.buf_wr_en,   32'(mBusy && mT == 0));
    checkOutput("macClear",   bus.mac_clear,   32'(mBusy && mT == 0));
    checkOutput("bufWrAddr",  bus.buf_wr_addr, 32'(mWp));
    checkOutput("macEn",      bus.mac_en,      32'(inMac));
    checkOutput("coeffAddr",  bus.coeff_addr,  inMac ? 32'(tap) : 32'd0);
    checkOutput("sampleAddr", bus.sample_addr,
                inMac ? 32'(((mWp - tap) % coeffSize + coeffSize) % coeffSize) : 32'd0);
    checkOutput("outValid",   bus.out_valid,   32'(mBusy && mT == outStart));
  end

  // Pulses in_valid for one cycle; returns at the negedge after the accept edge.
  task automatic applyStimulus();
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOutValid(output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 200) begin
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, bus.busy, 0);
  endtask

  initial begin
    int edges;
    int held;
    int n;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetInReady", bus.in_ready, 1);
    checkOutput("resetBusy",    bus.busy,     0);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] first sample");
    bus.out_ready = 1'b1;
    applyStimulus();
    checkOutput("s1LoadWrEn", bus.buf_wr_en,   1);
    checkOutput("s1LoadAddr", bus.buf_wr_addr, 0);
    waitOutValid(edges);
    checkOutput("s1Latency", edges, 67);
    @(negedge clock);
    checkOutput("s1BackIdle", bus.in_ready, 1);

    $display("[TB] second sample");
    applyStimulus();
    checkOutput("s2LoadAddr", bus.buf_wr_addr, 1);
    @(negedge clock);
    checkOutput("s2Sample0", bus.sample_addr, 1);
    @(negedge clock);
    checkOutput("s2Sample1", bus.sample_addr, 0);
    @(negedge clock);
    checkOutput("s2Sample2", bus.sample_addr, 63);
    checkOutput("s2Coeff2",  bus.coeff_addr,  2);
    waitOutValid(edges);
    checkOutput("s2OutValid", bus.out_valid, 1);
    @(negedge clock);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus();
    waitOutValid(edges);
    held = 0;
    repeat (10) begin
      if (bus.out_valid === 1'b1) held++;
      @(negedge clock);
    end
    checkOutput("bpHeld", held, 10);
    bus.out_ready = 1'b1;
    @(negedge clock);
    checkOutput("bpIdle", bus.busy, 0);

    $display("[TB] continuous in_valid");
    bus.in_valid = 1'b1;
    n = 0;
    while (acceptCount < 64 && n < 64 * 80) begin
      @(negedge clock);
      n++;
    end
    bus.in_valid = 1'b0;
    waitIdle("contIdle");
    checkOutput("wrapWrAddr", bus.buf_wr_addr, 0);

    $display("[TB] reset mid-MAC");
    applyStimulus();
    repeat (31) @(negedge clock);
    checkOutput("midCoeff",  bus.coeff_addr,  30);
    checkOutput("midSample", bus.sample_addr, 34);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    checkOutput("rstInReady", bus.in_ready,    1);
    checkOutput("rstBusy",    bus.busy,        0);
    checkOutput("rstMacEn",   bus.mac_en,      0);
    checkOutput("rstCoeff",   bus.coeff_addr,  0);
    checkOutput("rstWrAddr",  bus.buf_wr_addr, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rstNoOut", bus.out_valid, 0);
    applyStimulus();
    checkOutput("postRstAddr", bus.buf_wr_addr, 0);
    waitOutValid(edges);
    checkOutput("postRstLatency", edges, 67);
    @(negedge clock);

    $display("[TB] random traffic");
    repeat (6000) begin
      @(negedge clock);
      bus.in_valid  = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1999) == 0) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
